// File: rtl/blit_mem_responder.sv
// rtl/blit_mem_responder.sv - blitter bus-side memory responder with lane steering
// Optional watchdog on the RAM handshake: define RESP_TIMEOUT_EN.
module blit_mem_responder #(
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 64
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        bus_en,
    input  logic        mreq,
    input  logic        read,
    input  logic [3:0]  width,
    input  logic        justify,
    input  logic [23:0] blit_addr,
    input  logic [63:0] wdata,
    output logic        ack,
    output logic [63:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [20:0] mem_addr,
    output logic [7:0]  mem_be,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_rdy,
    output logic        busy,
    output logic        err
);

`ifdef RESP_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [63:0] DEAD_DATA = 64'hDEAD_DEAD_DEAD_DEAD;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REQ,
        ST_ACK
    } state_t;

    state_t state, state_nxt;

    logic          rv;
    logic [3:0]    wait_cnt;
    logic [TW-1:0] to_cnt;
    logic          timeout_hit;
    logic          err_q;

    logic          cap_read;
    logic          cap_justify;
    logic [2:0]    cap_off;
    logic [7:0]    cap_len_mask;
    logic [63:0]   rdata_q;

    logic [3:0]    in_n;
    logic [7:0]    in_len_mask;
    logic [7:0]    in_be;
    logic [63:0]   in_wdata;
    logic [63:0]   rd_steered;

    function automatic logic [63:0] lane_mask(input logic [7:0] be);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    assign rv = bus_en & mreq;

    // Out-of-range sizes collapse to a full phrase; lanes past byte 7 fall off the shift.
    always_comb begin
        in_n        = (width == 4'd0 || width > 4'd8) ? 4'd8 : width;
        in_len_mask = 8'hFF >> (4'd8 - in_n);
        in_be       = in_len_mask << blit_addr[2:0];
        in_wdata    = justify ? (wdata << {blit_addr[2:0], 3'b000}) : wdata;
        rd_steered  = cap_justify
                    ? ((mem_rdata >> {cap_off, 3'b000}) & lane_mask(cap_len_mask))
                    : (mem_rdata & lane_mask(mem_be));
    end

    assign timeout_hit = TO_EN && (state == ST_REQ) && !mem_rdy
                         && (to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (rv) state_nxt = ST_WAIT;
            ST_WAIT: if (wait_cnt == 4'd0) state_nxt = ST_REQ;
            ST_REQ:  if (mem_rdy || timeout_hit) state_nxt = ST_ACK;
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            wait_cnt     <= 4'd0;
            to_cnt       <= '0;
            err_q        <= 1'b0;
            cap_read     <= 1'b0;
            cap_justify  <= 1'b0;
            cap_off      <= 3'd0;
            cap_len_mask <= 8'd0;
            mem_we       <= 1'b0;
            mem_addr     <= 21'd0;
            mem_be       <= 8'd0;
            mem_wdata    <= 64'd0;
            rdata_q      <= 64'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rv) begin
                        cap_read     <= read;
                        cap_justify  <= justify;
                        cap_off      <= blit_addr[2:0];
                        cap_len_mask <= in_len_mask;
                        mem_we       <= ~read;
                        mem_addr     <= blit_addr[23:3];
                        mem_be       <= in_be;
                        mem_wdata    <= in_wdata;
                        wait_cnt     <= 4'(WAIT_STATES);
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_REQ: begin
                    to_cnt <= to_cnt + TW'(1);
                    if (mem_rdy) begin
                        rdata_q <= cap_read ? rd_steered : 64'd0;
                    end else if (timeout_hit) begin
                        rdata_q <= cap_read ? DEAD_DATA : 64'd0;
                        err_q   <= 1'b1;
                    end
                end
                ST_ACK: begin
                    to_cnt  <= '0;
                    rdata_q <= 64'd0;
                end
                default: ;
            endcase
        end
    end

    assign ack     = (state == ST_ACK);
    assign mem_req = (state == ST_REQ);
    assign busy    = (state != ST_IDLE);
    assign rdata   = rdata_q;
    assign err     = TO_EN ? err_q : 1'b0;

endmodule

// File: tb/tb_blit_mem_responder.sv
// tb/tb_blit_mem_responder.sv - randomized and directed bench for blit_mem_responder
module tb_blit_mem_responder;

    localparam int WS = 1;
    localparam int TO = 8;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        bus_en;
    logic        mreq;
    logic        read;
    logic [3:0]  width;
    logic        justify;
    logic [23:0] blit_addr;
    logic [63:0] wdata;
    logic        ack;
    logic [63:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [20:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_rdy;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fails  = 0;

    blit_mem_responder #(.WAIT_STATES(WS), .TIMEOUT(TO)) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .bus_en    (bus_en),
        .mreq      (mreq),
        .read      (read),
        .width     (width),
        .justify   (justify),
        .blit_addr (blit_addr),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy),
        .busy      (busy),
        .err       (err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int eff_n(input logic [3:0] w);
        return (w == 4'd0 || w > 4'd8) ? 8 : int'(w);
    endfunction

    function automatic logic [7:0] exp_be(input logic [3:0] w, input logic [23:0] a);
        logic [7:0] be;
        int o;
        be = '0;
        o  = int'(a[2:0]);
        for (int i = 0; i < eff_n(w); i++) begin
            if (o + i < 8) be[o + i] = 1'b1;
        end
        return be;
    endfunction

    function automatic logic [63:0] exp_wdata(input bit j, input logic [23:0] a, input logic [63:0] wd);
        logic [63:0] r;
        int o;
        if (!j) return wd;
        r = '0;
        o = int'(a[2:0]);
        for (int i = 0; i < 8; i++) begin
            if (o + i < 8) r[8*(o + i) +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [63:0] exp_rdata(input bit rd, input logic [3:0] w, input bit j,
                                              input logic [23:0] a, input logic [63:0] phrase);
        logic [63:0] r;
        logic [7:0]  be;
        int o;
        r  = '0;
        o  = int'(a[2:0]);
        be = exp_be(w, a);
        if (!rd) return r;
        if (j) begin
            for (int i = 0; i < eff_n(w); i++) begin
                if (o + i < 8) r[8*i +: 8] = phrase[8*(o + i) +: 8];
            end
        end else begin
            for (int l = 0; l < 8; l++) begin
                if (be[l]) r[8*l +: 8] = phrase[8*l +: 8];
            end
        end
        return r;
    endfunction

    // d = REQ cycle (0-based) in which mem_rdy is returned; d < 0 never returns it.
    task automatic run_txn(input string tag, input bit rd, input logic [3:0] w, input bit j,
                           input logic [23:0] a, input logic [63:0] wd, input logic [63:0] phrase,
                           input int d, input bit hold);
        int  k;
        int  nreq;
        int  exp_k;
        bit  got;
        bus_en    = 1'b1;
        mreq      = 1'b1;
        read      = rd;
        width     = w;
        justify   = j;
        blit_addr = a;
        wdata     = wd;
        @(posedge sys_clk);
        #1;
        if (!hold) begin
            mreq   = 1'b0;
            bus_en = 1'($urandom_range(0, 1));
        end
        read      = 1'($urandom);
        width     = 4'($urandom);
        justify   = 1'($urandom);
        blit_addr = 24'($urandom);
        wdata     = {$urandom, $urandom};
        check({tag, ".busy"}, 64'(busy), 64'd1);
        exp_k = (d < 0) ? WS + 1 + TO : WS + 2 + d;
        k = 0;
        nreq = 0;
        got = 1'b0;
        while (!got && k < 200) begin
            if (mem_req) begin
                if (nreq == 0) begin
                    check({tag, ".req_k"}, 64'(k), 64'(WS + 1));
                    check({tag, ".we"}, 64'(mem_we), 64'(!rd));
                    check({tag, ".addr"}, 64'(mem_addr), 64'(a[23:3]));
                    check({tag, ".be"}, 64'(mem_be), 64'(exp_be(w, a)));
                    if (!rd) check({tag, ".wdata"}, mem_wdata, exp_wdata(j, a, wd));
                end
                mem_rdy   = (nreq == d);
                mem_rdata = (nreq == d) ? phrase : {$urandom, $urandom};
                nreq++;
            end else begin
                mem_rdy = 1'b0;
            end
            if (ack) begin
                got = 1'b1;
                check({tag, ".ack_k"}, 64'(k), 64'(exp_k));
                check({tag, ".req_len"}, 64'(nreq), 64'((d < 0) ? TO : d + 1));
                if (d < 0) check({tag, ".rdata"}, rdata, rd ? 64'hDEAD_DEAD_DEAD_DEAD : 64'd0);
                else       check({tag, ".rdata"}, rdata, exp_rdata(rd, w, j, a, phrase));
            end else begin
                @(posedge sys_clk);
                #1;
                k++;
            end
        end
        check({tag, ".ack_seen"}, 64'(got), 64'd1);
        mem_rdy = 1'b0;
        @(posedge sys_clk);
        #1;
        check({tag, ".ack_once"}, 64'(ack), 64'd0);
        check({tag, ".idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int k;
        bit hold;
        reset = 1'b1; bus_en = 1'b0; mreq = 1'b0; read = 1'b0; width = 4'd0;
        justify = 1'b0; blit_addr = 24'd0; wdata = 64'd0; mem_rdata = 64'd0; mem_rdy = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst.ack", 64'(ack), 64'd0);
        check("rst.mem_req", 64'(mem_req), 64'd0);
        check("rst.mem_we", 64'(mem_we), 64'd0);
        check("rst.mem_be", 64'(mem_be), 64'd0);
        check("rst.mem_addr", 64'(mem_addr), 64'd0);
        check("rst.mem_wdata", mem_wdata, 64'd0);
        check("rst.rdata", rdata, 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.err", 64'(err), 64'd0);
        reset = 1'b0;
        @(posedge sys_clk);
        #1;

        run_txn("t1", 1'b0, 4'd2, 1'b1, 24'h000105, 64'h0000_0000_0000_BEEF, 64'd0, 0, 1'b0);
        run_txn("t2", 1'b1, 4'd4, 1'b1, 24'h000004, 64'd0, 64'h1122_3344_5566_7788, 0, 1'b0);
        run_txn("t3", 1'b1, 4'd8, 1'b0, 24'h000006, 64'd0, 64'h1122_3344_5566_7788, 1, 1'b0);
        run_txn("t4a", 1'b0, 4'd8, 1'b0, 24'h000040, 64'h0123_4567_89AB_CDEF, 64'd0, 3, 1'b1);
        run_txn("t4b", 1'b0, 4'd3, 1'b1, 24'h000043, 64'h0000_0000_00AA_BBCC, 64'd0, 3, 1'b0);
        run_txn("w0", 1'b1, 4'd0, 1'b1, 24'h000003, 64'd0, 64'hFEDC_BA98_7654_3210, 2, 1'b0);

        for (int i = 0; i < 40; i++) begin
            hold = (i != 39) && ($urandom_range(0, 3) == 0);
            run_txn("rnd", 1'($urandom), 4'($urandom), 1'($urandom), 24'($urandom),
                    {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 4), hold);
        end

        bus_en = 1'b1; mreq = 1'b1; read = 1'b0; width = 4'd4; justify = 1'b1;
        blit_addr = 24'h000200; wdata = 64'h5555;
        @(posedge sys_clk);
        #1;
        mreq = 1'b0;
        k = 0;
        while (!mem_req && k < 20) begin
            @(posedge sys_clk);
            #1;
            k++;
        end
        check("t5.in_req", 64'(mem_req), 64'd1);
        reset = 1'b1;
        @(posedge sys_clk);
        #1;
        reset = 1'b0;
        check("t5.mem_req", 64'(mem_req), 64'd0);
        check("t5.ack", 64'(ack), 64'd0);
        check("t5.busy", 64'(busy), 64'd0);
        run_txn("t5.fresh", 1'b1, 4'd2, 1'b1, 24'h000207, 64'd0, 64'hA1B2_C3D4_E5F6_0718, 0, 1'b0);

`ifdef RESP_TIMEOUT_EN
        run_txn("t6", 1'b1, 4'd8, 1'b0, 24'h000010, 64'd0, 64'd0, -1, 1'b0);
        check("t6.err", 64'(err), 64'd1);
        run_txn("t6.after", 1'b0, 4'd1, 1'b1, 24'h000011, 64'h77, 64'd0, 0, 1'b0);
        check("t6.err_sticky", 64'(err), 64'd1);
        reset = 1'b1;
        @(posedge sys_clk);
        #1;
        reset = 1'b0;
        check("t6.err_clr", 64'(err), 64'd0);
`else
        check("err_tied", 64'(err), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
